// File: rtl/xpoint_ctrl_pkg.sv
// xpoint_ctrl_pkg: shared defaults and pointer-width helper for the 2x2 crosspoint stage
package xpoint_ctrl_pkg;
  localparam int FLIT_SIZE_D  = 64;
  localparam int TURN_BIT_D   = 63;
  localparam int FIFO_DEPTH_D = 2;
  localparam int CNT_W_D      = 16;
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
  localparam int PTR_W_D = ptr_w(FIFO_DEPTH_D);
endpackage

// File: rtl/xpoint_ctrl_flit_fifo.sv
// flit_fifo: power-of-two circular flit buffer with async active-high reset
// Ports: clk/rst; i_push+i_din write; i_pop read; o_head = oldest entry; o_count = occupancy.
// The caller guarantees no push when full and no pop when empty.
module flit_fifo
  import xpoint_ctrl_pkg::*;
#(
  parameter int W = FLIT_SIZE_D,
  parameter int D = FIFO_DEPTH_D
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_push,
  input  logic [W-1:0]        i_din,
  input  logic                i_pop,
  output logic [W-1:0]        o_head,
  output logic [ptr_w(D):0]   o_count
);
  localparam int PW = ptr_w(D);
  logic [W-1:0]  r_mem [D];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [PW:0]   r_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + PW'(1);
      if (i_pop) r_rd <= r_rd + PW'(1);
      r_cnt <= r_cnt + (PW+1)'(i_push) - (PW+1)'(i_pop);
    end
  end
  // storage needs no reset: only entries between the pointers are ever read
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr] <= i_din;
  end
  assign o_head  = r_mem[r_rd];
  assign o_count = r_cnt;
endmodule

// File: rtl/xpoint_ctrl.sv
// xpoint_ctrl: flow-controlled 2x2 crosspoint with per-input FIFOs and round-robin conflict arbitration
// Ports: h_in/v_in (+valid/ready) flit inputs; h_out/v_out (+valid/ready) registered outputs;
// cross_enable = turn bit of the last moved flit; conflict_cnt = saturating count of conflict cycles.
module xpoint_ctrl
  import xpoint_ctrl_pkg::*;
#(
  parameter int FLIT_SIZE  = FLIT_SIZE_D,
  parameter int TURN_BIT   = TURN_BIT_D,
  parameter int FIFO_DEPTH = FIFO_DEPTH_D,
  parameter int CNT_W      = CNT_W_D
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FLIT_SIZE-1:0] h_in,
  input  logic                 h_in_valid,
  output logic                 h_in_ready,
  input  logic [FLIT_SIZE-1:0] v_in,
  input  logic                 v_in_valid,
  output logic                 v_in_ready,
  output logic [FLIT_SIZE-1:0] h_out,
  output logic                 h_out_valid,
  input  logic                 h_out_ready,
  output logic [FLIT_SIZE-1:0] v_out,
  output logic                 v_out_valid,
  input  logic                 v_out_ready,
  output logic                 cross_enable,
  output logic [CNT_W-1:0]     conflict_cnt
);
  localparam int PW = ptr_w(FIFO_DEPTH);
  logic [FLIT_SIZE-1:0] w_h_head, w_v_head, w_ho_d, w_vo_d;
  logic [PW:0]          w_h_cnt, w_v_cnt;
  logic w_h_has, w_v_has, w_h_turn, w_v_turn, w_h_free, w_v_free, w_h_tf, w_v_tf;
  logic w_conf, w_h_mv, w_v_mv, w_ho_ld, w_vo_ld;
  logic [FLIT_SIZE-1:0] r_h_out, r_v_out;
  logic                 r_h_val, r_v_val, r_cross, r_prio;
  logic [CNT_W-1:0]     r_cnt;
  flit_fifo #(.W(FLIT_SIZE), .D(FIFO_DEPTH)) u_h_fifo (
    .clk(clk), .rst(rst), .i_push(h_in_valid & h_in_ready), .i_din(h_in),
    .i_pop(w_h_mv), .o_head(w_h_head), .o_count(w_h_cnt)
  );
  flit_fifo #(.W(FLIT_SIZE), .D(FIFO_DEPTH)) u_v_fifo (
    .clk(clk), .rst(rst), .i_push(v_in_valid & v_in_ready), .i_din(v_in),
    .i_pop(w_v_mv), .o_head(w_v_head), .o_count(w_v_cnt)
  );
  assign h_in_ready = w_h_cnt < (PW+1)'(FIFO_DEPTH);
  assign v_in_ready = w_v_cnt < (PW+1)'(FIFO_DEPTH);
  always_comb begin
    w_h_has  = w_h_cnt != '0;
    w_v_has  = w_v_cnt != '0;
    w_h_turn = w_h_head[TURN_BIT];
    w_v_turn = w_v_head[TURN_BIT];
    w_h_free = !r_h_val | h_out_ready;
    w_v_free = !r_v_val | v_out_ready;
    // free status of each head's target; h turns to v_out, v turns to h_out
    w_h_tf   = w_h_turn ? w_v_free : w_h_free;
    w_v_tf   = w_v_turn ? w_h_free : w_v_free;
    // differing turn bits means both heads aim at the same output
    w_conf   = w_h_has & w_v_has & (w_h_turn ^ w_v_turn);
    w_h_mv   = w_h_has & w_h_tf & !(w_conf & r_prio);
    w_v_mv   = w_v_has & w_v_tf & !(w_conf & !r_prio);
    w_ho_ld  = (w_h_mv & !w_h_turn) | (w_v_mv & w_v_turn);
    w_vo_ld  = (w_h_mv & w_h_turn) | (w_v_mv & !w_v_turn);
    w_ho_d   = (w_h_mv & !w_h_turn) ? w_h_head : w_v_head;
    w_vo_d   = (w_h_mv & w_h_turn) ? w_h_head : w_v_head;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h_out <= '0;
      r_v_out <= '0;
      r_h_val <= 1'b0;
      r_v_val <= 1'b0;
      r_cross <= 1'b0;
      r_prio  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (w_ho_ld) begin
        r_h_out <= w_ho_d;
        r_h_val <= 1'b1;
      end else if (h_out_ready) r_h_val <= 1'b0;
      if (w_vo_ld) begin
        r_v_out <= w_vo_d;
        r_v_val <= 1'b1;
      end else if (v_out_ready) r_v_val <= 1'b0;
      // without a conflict any two movers share the same turn bit
      if (w_h_mv | w_v_mv) r_cross <= w_h_mv ? w_h_turn : w_v_turn;
      if (w_conf & (w_h_mv | w_v_mv)) r_prio <= ~r_prio;
      if (w_conf & ~&r_cnt) r_cnt <= r_cnt + CNT_W'(1);
    end
  end
  assign h_out        = r_h_out;
  assign v_out        = r_v_out;
  assign h_out_valid  = r_h_val;
  assign v_out_valid  = r_v_val;
  assign cross_enable = r_cross;
  assign conflict_cnt = r_cnt;
endmodule

// File: tb/tb_xpoint_ctrl.sv
// tb_xpoint_ctrl: directed stimulus with a queue-based reference model checked every cycle
module tb_xpoint_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] h_in = '0, v_in = '0;
  logic        h_in_valid = 1'b0, v_in_valid = 1'b0;
  logic        h_out_ready = 1'b1, v_out_ready = 1'b1;
  logic        h_in_ready, v_in_ready, h_out_valid, v_out_valid, cross_enable;
  logic [63:0] h_out, v_out;
  logic [15:0] conflict_cnt;
  logic        d2_h_in_ready, d2_v_in_ready, d2_h_out_valid, d2_v_out_valid, d2_cross;
  logic [63:0] d2_h_out, d2_v_out;
  logic [1:0]  d2_cnt;
  int n_chk = 0;
  int n_fail = 0;
  xpoint_ctrl dut (
    .clk(clk), .rst(rst),
    .h_in(h_in), .h_in_valid(h_in_valid), .h_in_ready(h_in_ready),
    .v_in(v_in), .v_in_valid(v_in_valid), .v_in_ready(v_in_ready),
    .h_out(h_out), .h_out_valid(h_out_valid), .h_out_ready(h_out_ready),
    .v_out(v_out), .v_out_valid(v_out_valid), .v_out_ready(v_out_ready),
    .cross_enable(cross_enable), .conflict_cnt(conflict_cnt)
  );
  xpoint_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .h_in(h_in), .h_in_valid(h_in_valid), .h_in_ready(d2_h_in_ready),
    .v_in(v_in), .v_in_valid(v_in_valid), .v_in_ready(d2_v_in_ready),
    .h_out(d2_h_out), .h_out_valid(d2_h_out_valid), .h_out_ready(h_out_ready),
    .v_out(d2_v_out), .v_out_valid(d2_v_out_valid), .v_out_ready(v_out_ready),
    .cross_enable(d2_cross), .conflict_cnt(d2_cnt)
  );
  always #5 clk = ~clk;
  logic [63:0] hq[$], vq[$];
  logic [63:0] m_h_out, m_v_out;
  logic        m_h_v, m_v_v, m_ce, m_prio;
  int          m_cnt, m_cnt2;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    hq.delete();
    vq.delete();
    m_h_out = '0;
    m_v_out = '0;
    m_h_v = 1'b0;
    m_v_v = 1'b0;
    m_ce = 1'b0;
    m_prio = 1'b0;
    m_cnt = 0;
    m_cnt2 = 0;
  endtask
  // one clock of the crosspoint rules: targets 0 = h_out, 1 = v_out
  task automatic model_step();
    bit hh, vh, hr, vr, ht, vt, conf, hg, vg;
    bit fr[2];
    bit ld[2];
    logic [63:0] d[2];
    int htgt, vtgt;
    hh = hq.size() > 0;
    vh = vq.size() > 0;
    hr = hq.size() < 2;
    vr = vq.size() < 2;
    ht = hh && hq[0][63];
    vt = vh && vq[0][63];
    htgt = ht ? 1 : 0;
    vtgt = vt ? 0 : 1;
    fr[0] = !m_h_v || h_out_ready;
    fr[1] = !m_v_v || v_out_ready;
    conf = hh && vh && (htgt == vtgt);
    hg = hh && fr[htgt] && !(conf && m_prio);
    vg = vh && fr[vtgt] && !(conf && !m_prio);
    ld[0] = 1'b0;
    ld[1] = 1'b0;
    d[0] = '0;
    d[1] = '0;
    if (hg) begin ld[htgt] = 1'b1; d[htgt] = hq.pop_front(); end
    if (vg) begin ld[vtgt] = 1'b1; d[vtgt] = vq.pop_front(); end
    if (conf) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
      if (hg || vg) m_prio = !m_prio;
    end
    if (hg || vg) m_ce = hg ? ht : vt;
    if (ld[0]) begin m_h_out = d[0]; m_h_v = 1'b1; end else if (h_out_ready) m_h_v = 1'b0;
    if (ld[1]) begin m_v_out = d[1]; m_v_v = 1'b1; end else if (v_out_ready) m_v_v = 1'b0;
    if (h_in_valid && hr) hq.push_back(h_in);
    if (v_in_valid && vr) vq.push_back(v_in);
  endtask
  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else model_step();
  end
  always @(negedge clk) begin
    chk("h_in_ready", h_in_ready, hq.size() < 2);
    chk("v_in_ready", v_in_ready, vq.size() < 2);
    chk("h_out_valid", h_out_valid, m_h_v);
    chk("v_out_valid", v_out_valid, m_v_v);
    if (m_h_v) chk("h_out", h_out, m_h_out);
    if (m_v_v) chk("v_out", v_out, m_v_out);
    chk("cross_enable", cross_enable, m_ce);
    chk("conflict_cnt", conflict_cnt, m_cnt);
    chk("d2_h_out_valid", d2_h_out_valid, m_h_v);
    chk("d2_v_out_valid", d2_v_out_valid, m_v_v);
    if (m_h_v) chk("d2_h_out", d2_h_out, m_h_out);
    if (m_v_v) chk("d2_v_out", d2_v_out, m_v_out);
    chk("d2_ready", {d2_h_in_ready, d2_v_in_ready}, {hq.size() < 2, vq.size() < 2});
    chk("d2_cross", d2_cross, m_ce);
    chk("d2_conflict_cnt", d2_cnt, m_cnt2);
  end
  task automatic cyc(input bit hv, input logic [63:0] hd, input bit vv, input logic [63:0] vd);
    h_in_valid = hv;
    h_in = hd;
    v_in_valid = vv;
    v_in = vd;
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [63:0] hs[3], vs[3], ord[6], bp[3], rh[3], rv[3];
    int hi, vi;
    bit hv, vv;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_h_out_valid", h_out_valid, 0);
    chk("rst_v_out_valid", v_out_valid, 0);
    chk("rst_h_out", h_out, 0);
    chk("rst_v_out", v_out, 0);
    chk("rst_cross", cross_enable, 0);
    chk("rst_cnt", conflict_cnt, 0);
    rst = 1'b0;
    #1;
    chk("rel_ready", {h_in_ready, v_in_ready}, 2'b11);
    // straight
    cyc(1, 64'hA1, 1, 64'hB2);
    cyc(0, 0, 0, 0);
    chk("str_h_out", h_out, 64'hA1);
    chk("str_v_out", v_out, 64'hB2);
    chk("str_valid", {h_out_valid, v_out_valid}, 2'b11);
    chk("str_cross", cross_enable, 0);
    chk("str_cnt", conflict_cnt, 0);
    cyc(0, 0, 0, 0);
    // full cross
    cyc(1, 64'h8000_0000_0000_00C3, 1, 64'h8000_0000_0000_00D4);
    cyc(0, 0, 0, 0);
    chk("x_h_out", h_out, 64'h8000_0000_0000_00D4);
    chk("x_v_out", v_out, 64'h8000_0000_0000_00C3);
    chk("x_valid", {h_out_valid, v_out_valid}, 2'b11);
    chk("x_cross", cross_enable, 1);
    cyc(0, 0, 0, 0);
    // conflict round-robin on h_out
    hs[0] = 64'hE1; hs[1] = 64'hE2; hs[2] = 64'hE3;
    vs[0] = 64'h8000_0000_0000_00F1; vs[1] = 64'h8000_0000_0000_00F2; vs[2] = 64'h8000_0000_0000_00F3;
    ord[0] = hs[0]; ord[1] = vs[0]; ord[2] = hs[1]; ord[3] = vs[1]; ord[4] = hs[2]; ord[5] = vs[2];
    hi = 0;
    vi = 0;
    for (int c = 0; c < 7; c++) begin
      bit ha, va;
      hv = hi < 3;
      vv = vi < 3;
      ha = hv && hq.size() < 2;
      va = vv && vq.size() < 2;
      cyc(hv, hv ? hs[hi] : 64'h0, vv, vv ? vs[vi] : 64'h0);
      if (ha) hi++;
      if (va) vi++;
      if (c >= 1) begin
        chk("rr_h_out", h_out, ord[c-1]);
        chk("rr_h_valid", h_out_valid, 1);
        chk("rr_v_valid", v_out_valid, 0);
      end
      if (c == 4) begin
        chk("rr_cnt4", conflict_cnt, 4);
        chk("sat_cnt4", d2_cnt, 3);
      end
      if (c == 5) chk("sat_cnt5", d2_cnt, 3);
    end
    chk("rr_cnt_final", conflict_cnt, 5);
    cyc(0, 0, 0, 0);
    // backpressure on h_out
    bp[0] = 64'h11; bp[1] = 64'h22; bp[2] = 64'h33;
    h_out_ready = 1'b0;
    hi = 0;
    for (int c = 0; c < 6; c++) begin
      bit ha;
      hv = hi < 3;
      ha = hv && hq.size() < 2;
      cyc(hv, hv ? bp[hi] : 64'h0, 0, 0);
      if (ha) hi++;
      if (c >= 2) chk("bp_hold", h_out, 64'h11);
    end
    chk("bp_valid", h_out_valid, 1);
    chk("bp_in_ready", h_in_ready, 0);
    h_out_ready = 1'b1;
    cyc(0, 0, 0, 0);
    chk("bp_drain1", h_out, 64'h22);
    cyc(0, 0, 0, 0);
    chk("bp_drain2", h_out, 64'h33);
    chk("bp_drain_valid", h_out_valid, 1);
    cyc(0, 0, 0, 0);
    chk("bp_empty", h_out_valid, 0);
    // async reset with full FIFOs and held outputs
    rh[0] = 64'h44; rh[1] = 64'h55; rh[2] = 64'h66;
    rv[0] = 64'h77; rv[1] = 64'h88; rv[2] = 64'h99;
    h_out_ready = 1'b0;
    v_out_ready = 1'b0;
    for (int c = 0; c < 3; c++) cyc(1, rh[c], 1, rv[c]);
    chk("pre_rst_full", {h_in_ready, v_in_ready}, 2'b00);
    chk("pre_rst_valid", {h_out_valid, v_out_valid}, 2'b11);
    h_in_valid = 1'b0;
    v_in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", {h_out_valid, v_out_valid}, 2'b00);
    chk("arst_cnt", conflict_cnt, 0);
    chk("arst_cross", cross_enable, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    h_out_ready = 1'b1;
    v_out_ready = 1'b1;
    chk("post_rst_ready", {h_in_ready, v_in_ready}, 2'b11);
    for (int c = 0; c < 3; c++) begin
      cyc(0, 0, 0, 0);
      chk("post_rst_no_stale", {h_out_valid, v_out_valid}, 2'b00);
    end
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
